// File: rtl/fft_frame_sequencer_pkg.sv
// Shared constants and types for the FFT frame sequencer.
// Holds the FFT geometry, the fixed core latency, the cpu_if register map
// and the sequencer state encoding.
package fft_frame_sequencer_pkg;

    localparam int NO_STAGES    = 4;
    localparam int N_POINT_FFT  = 2 ** NO_STAGES;
    localparam int CORE_LATENCY = 10;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] IN_OFS     = 32'h0000_0100;
    localparam logic [31:0] OUT_OFS    = 32'h0000_0200;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_CLR_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/fft_frame_sequencer_sample_buffer.sv
// N x SW sample register bank with a single-sample write port, a whole-frame
// bulk load port and a single-sample read mux. The full frame is also exposed
// flat, sample i at frame_o[i*SW +: SW].
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset (clears all samples)
//   wr_en_i/idx/data    single-sample write
//   load_en_i/data      bulk frame load, has priority over the write port
//   rd_idx_i, rd_data_o combinational single-sample read
//   frame_o             flat view of the stored frame
module fft_frame_sequencer_sample_buffer #(
    parameter int N  = 16,
    parameter int SW = 16,
    parameter int IW = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            wr_en_i,
    input  logic [IW-1:0]   wr_idx_i,
    input  logic [SW-1:0]   wr_data_i,
    input  logic            load_en_i,
    input  logic [N*SW-1:0] load_data_i,
    input  logic [IW-1:0]   rd_idx_i,
    output logic [SW-1:0]   rd_data_o,
    output logic [N*SW-1:0] frame_o
);

    logic [N*SW-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (load_en_i) begin
            mem_d = load_data_i;
        end else if (wr_en_i) begin
            mem_d[int'(wr_idx_i)*SW +: SW] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_o = mem_q[int'(rd_idx_i)*SW +: SW];
    assign frame_o   = mem_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// CPU-facing sequencer for the 16-point FFT core. The CPU loads a frame into
// IN[], starts a pass, the core result is captured into OUT[] after the fixed
// core latency and completion is flagged in STATUS.done / irq_o.
// Ports:
//   clk_i, reset_n_i            clock, async active-low reset
//   cpu_if_*_i / cpu_if_*_o     register port; 1-cycle ack, registered read data
//   core_x_N_o, core_in_valid_o frame and launch pulse to the core
//   core_y_N_i                  core result frame
//   irq_o, error_o              STATUS.done and STATUS.err levels
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | no frame in flight, IN[] writable
// ST_LAUNCH  | core_in_valid_o pulse, latency counter running
// ST_WAIT    | waiting for core result, counter counts down to 0
// ST_CAPTURE | core_y_N_i valid: load OUT[], set done
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  cpu_if_read_i,
    input  logic                                  cpu_if_write_i,
    input  logic [ADDR_WIDTH-1:0]                 cpu_if_address_i,
    input  logic [DATA_WIDTH-1:0]                 cpu_if_write_data_i,
    output logic [DATA_WIDTH-1:0]                 cpu_if_read_data_o,
    output logic                                  cpu_if_access_complete_o,
    output logic [N_POINT_FFT*(DATA_WIDTH/2)-1:0] core_x_N_o,
    output logic                                  core_in_valid_o,
    input  logic [N_POINT_FFT*(DATA_WIDTH/2)-1:0] core_y_N_i,
    output logic                                  irq_o,
    output logic                                  error_o
);

    localparam int SW = DATA_WIDTH / 2;
    localparam int IW = NO_STAGES;
    localparam int CW = $clog2(CORE_LATENCY);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_d;

    logic                    rd_req, wr_req, collide, busy, aligned;
    logic                    sel_ctrl, sel_status, sel_in, sel_out;
    logic                    start_req, start_ok, clr_req, err_clr;
    logic                    in_wr_req, in_wr_en, err_evt, out_load;
    logic [IW-1:0]           word_idx;
    logic [SW-1:0]           in_rd_data, out_rd_data;
    logic [N_POINT_FFT*SW-1:0] out_frame_unused;
    logic                    wdata_unused;

    // A simultaneous read and write is rejected as a whole: neither side acts.
    assign rd_req  = cpu_if_read_i & ~cpu_if_write_i;
    assign wr_req  = cpu_if_write_i & ~cpu_if_read_i;
    assign collide = cpu_if_read_i & cpu_if_write_i;
    assign busy    = (state_q != ST_IDLE);

    assign aligned    = (cpu_if_address_i[1:0] == 2'b00);
    assign word_idx   = cpu_if_address_i[IW+1:2];
    assign sel_ctrl   = (cpu_if_address_i == ADDR_WIDTH'(CTRL_OFS));
    assign sel_status = (cpu_if_address_i == ADDR_WIDTH'(STATUS_OFS));
    assign sel_in     = aligned &&
        ({cpu_if_address_i[ADDR_WIDTH-1:IW+2], {(IW+2){1'b0}}} == ADDR_WIDTH'(IN_OFS));
    assign sel_out    = aligned &&
        ({cpu_if_address_i[ADDR_WIDTH-1:IW+2], {(IW+2){1'b0}}} == ADDR_WIDTH'(OUT_OFS));

    assign start_req = wr_req & sel_ctrl & cpu_if_write_data_i[CTRL_START_BIT];
    assign clr_req   = wr_req & sel_ctrl & cpu_if_write_data_i[CTRL_CLR_DONE_BIT];
    assign err_clr   = wr_req & sel_status & cpu_if_write_data_i[STATUS_ERR_BIT];
    assign in_wr_req = wr_req & sel_in;

    // core_x_N_o comes straight from IN[], so IN[] is frozen while busy.
    assign start_ok = start_req & ~busy;
    assign in_wr_en = in_wr_req & ~busy;
    assign err_evt  = collide | (start_req & busy) | (in_wr_req & busy);

    assign wdata_unused = ^cpu_if_write_data_i[DATA_WIDTH-1:SW];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        core_in_valid_o = 1'b0;
        out_load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_LAUNCH;
                    // Counting starts in LAUNCH so CAPTURE lands exactly
                    // CORE_LATENCY cycles after the launch pulse.
                    cnt_d   = CW'(CORE_LATENCY - 1);
                end
            end
            ST_LAUNCH: begin
                core_in_valid_o = 1'b1;
                cnt_d           = cnt_q - CW'(1);
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CAPTURE: begin
                out_load = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_d = done_q;
        if (clr_req)  done_d = 1'b0;
        if (out_load) done_d = 1'b1;
        if (start_ok) done_d = 1'b0;

        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_evt) err_d = 1'b1;

        rdata_d = cpu_if_read_data_o;
        if (rd_req) begin
            rdata_d = '0;
            if (sel_status) begin
                rdata_d = {{(DATA_WIDTH-3){1'b0}}, err_q, done_q, busy};
            end else if (sel_in) begin
                rdata_d = {{(DATA_WIDTH-SW){1'b0}}, in_rd_data};
            end else if (sel_out) begin
                rdata_d = {{(DATA_WIDTH-SW){1'b0}}, out_rd_data};
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q                  <= ST_IDLE;
            cnt_q                    <= '0;
            done_q                   <= 1'b0;
            err_q                    <= 1'b0;
            cpu_if_read_data_o       <= '0;
            cpu_if_access_complete_o <= 1'b0;
        end else begin
            state_q                  <= state_d;
            cnt_q                    <= cnt_d;
            done_q                   <= done_d;
            err_q                    <= err_d;
            cpu_if_read_data_o       <= rdata_d;
            cpu_if_access_complete_o <= cpu_if_read_i | cpu_if_write_i;
        end
    end

    assign irq_o   = done_q;
    assign error_o = err_q;

    fft_frame_sequencer_sample_buffer #(
        .N  (N_POINT_FFT),
        .SW (SW),
        .IW (IW)
    ) u_in_buf (
        .clk_i       (clk_i),
        .rst_n_i     (reset_n_i),
        .wr_en_i     (in_wr_en),
        .wr_idx_i    (word_idx),
        .wr_data_i   (cpu_if_write_data_i[SW-1:0]),
        .load_en_i   (1'b0),
        .load_data_i ('0),
        .rd_idx_i    (word_idx),
        .rd_data_o   (in_rd_data),
        .frame_o     (core_x_N_o)
    );

    fft_frame_sequencer_sample_buffer #(
        .N  (N_POINT_FFT),
        .SW (SW),
        .IW (IW)
    ) u_out_buf (
        .clk_i       (clk_i),
        .rst_n_i     (reset_n_i),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_data_i   ('0),
        .load_en_i   (out_load),
        .load_data_i (core_y_N_i),
        .rd_idx_i    (word_idx),
        .rd_data_o   (out_rd_data),
        .frame_o     (out_frame_unused)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
    import fft_frame_sequencer_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 2;
    localparam int N  = N_POINT_FFT;
    localparam int L  = CORE_LATENCY;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rd = 1'b0, wr = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   wdata = '0;
    logic [DW-1:0]   rdata;
    logic            ack;
    logic [N*SW-1:0] x_n, y_n;
    logic            civ, irq, err;

    fft_frame_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i                    (clk),
        .reset_n_i                (rst_n),
        .cpu_if_read_i            (rd),
        .cpu_if_write_i           (wr),
        .cpu_if_address_i         (addr),
        .cpu_if_write_data_i      (wdata),
        .cpu_if_read_data_o       (rdata),
        .cpu_if_access_complete_o (ack),
        .core_x_N_o               (x_n),
        .core_in_valid_o          (civ),
        .core_y_N_i               (y_n),
        .irq_o                    (irq),
        .error_o                  (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model core: y = 2*x per sample, valid exactly L cycles after the launch.
    function automatic logic [N*SW-1:0] dbl(input logic [N*SW-1:0] x);
        logic [N*SW-1:0] r;
        for (int i = 0; i < N; i++) r[i*SW +: SW] = x[i*SW +: SW] << 1;
        return r;
    endfunction

    logic [L-1:0]    pv;
    logic [N*SW-1:0] pd [L];
    always @(posedge clk) begin
        pv    <= {pv[L-2:0], civ};
        pd[0] <= dbl(x_n);
        for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
    assign y_n = (pv[L-1] === 1'b1) ? pd[L-1] : {N{16'hDEAD}};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    endtask

    typedef struct {
        int            cyc;
        bit            chk;
        logic [DW-1:0] data;
        string         name;
    } exp_t;
    exp_t sb[$];
    exp_t m_e;

    // Monitor: every ack pops one expectation and checks its cycle and data.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ack === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: ack at cycle %0d, expected no ack", cyc);
                end else begin
                    m_e = sb.pop_front();
                    check({m_e.name, "_ack_cycle"}, DW'(cyc), DW'(m_e.cyc));
                    if (m_e.chk) check({m_e.name, "_data"}, rdata, m_e.data);
                end
            end
        end
    end

    int launches = 0;
    int last_launch = -1;
    initial begin
        forever begin
            @(negedge clk);
            if (civ === 1'b1) begin
                launches++;
                last_launch = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end at a drive slot 2 time units after posedge.
    task automatic access(input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit chkd,
                          input logic [DW-1:0] want, input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.chk  = chkd;
        e.data = want;
        e.name = name;
        sb.push_back(e);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #2;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
        access(1'b0, 1'b1, a, d, 1'b0, '0, name);
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, input logic [DW-1:0] want, input string name);
        access(1'b1, 1'b0, a, '0, 1'b1, want, name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start(output int c);
        c = cyc;
        cpu_wr(CTRL_OFS, 32'h1, "start");
    endtask

    task automatic wait_irq(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq === 1'b1) begin
                at = cyc;
                break;
            end
        end
        @(posedge clk); #2;
    endtask

    initial begin
        int c, at, base;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_irq", DW'(irq), 0);
        check("rst_error", DW'(err), 0);
        check("rst_core_in_valid", DW'(civ), 0);
        check("rst_ack", DW'(ack), 0);
        check("rst_read_data", rdata, 0);
        check("rst_core_x", x_n[DW-1:0], 0);
        rst_n = 1'b1;
        idle(2);

        // 1: reset mid-WAIT aborts the frame
        cpu_wr(IN_OFS, 32'h11, "t1_in0");
        cpu_wr(IN_OFS + 4, 32'h22, "t1_in1");
        start(c);
        idle(4);
        rst_n = 1'b0;
        #1;
        check("t1_rst_core_x", x_n[DW-1:0], 0);
        check("t1_rst_irq", DW'(irq), 0);
        check("t1_rst_civ", DW'(civ), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1);
        cpu_rd(STATUS_OFS, 32'h0, "t1_status");
        idle(20);
        check("t1_no_late_irq", DW'(irq), 0);
        check("t1_launch_count", DW'(launches), 1);
        cpu_rd(OUT_OFS, 32'h0, "t1_out0");
        cpu_rd(IN_OFS, 32'h0, "t1_in0_cleared");

        // 2: full frame
        for (int i = 0; i < N; i++) cpu_wr(IN_OFS + 4*i, DW'(i + 1), "t2_in");
        check("t2_core_x3", DW'(x_n[3*SW +: SW]), 4);
        base = launches;
        start(c);
        wait_irq(at);
        check("t2_irq_cycle", DW'(at), DW'(c + 12));
        check("t2_launch_cycle", DW'(last_launch), DW'(c + 1));
        check("t2_single_launch", DW'(launches), DW'(base + 1));
        for (int i = 0; i < N; i++) cpu_rd(OUT_OFS + 4*i, DW'(2*(i + 1)), "t2_out");

        // 3: busy protection
        base = launches;
        start(c);
        idle(2);
        cpu_wr(IN_OFS + 12, 32'hFFFF, "t3_in3_busy");
        cpu_wr(CTRL_OFS, 32'h1, "t3_start_busy");
        cpu_rd(STATUS_OFS, 32'h5, "t3_status_busy");
        check("t3_core_x3", DW'(x_n[3*SW +: SW]), 4);
        wait_irq(at);
        check("t3_irq_cycle", DW'(at), DW'(c + 12));
        check("t3_single_launch", DW'(launches), DW'(base + 1));
        cpu_rd(STATUS_OFS, 32'h6, "t3_status_done");
        cpu_rd(IN_OFS + 12, 32'h4, "t3_in3");
        cpu_rd(OUT_OFS + 12, 32'h8, "t3_out3");
        cpu_wr(STATUS_OFS, 32'h4, "t3_err_w1c");
        cpu_rd(STATUS_OFS, 32'h2, "t3_status_cleared");

        // 4: back-to-back reads, unmapped and read-only targets
        cpu_rd(32'h3FC, 32'h0, "t4_unmapped");
        cpu_rd(STATUS_OFS, 32'h2, "t4_status");
        cpu_rd(CTRL_OFS, 32'h0, "t4_ctrl");
        cpu_rd(IN_OFS + 60, 32'h10, "t4_in15");
        idle(3);
        check("t4_rdata_hold", rdata, 32'h10);
        cpu_wr(32'h140, 32'hAAAA, "t4_wr_unmapped");
        cpu_rd(IN_OFS, 32'h1, "t4_in0_no_alias");
        cpu_wr(OUT_OFS, 32'h5555, "t4_wr_out");
        cpu_rd(OUT_OFS, 32'h2, "t4_out0_ro");

        // 5: collisions
        access(1'b1, 1'b1, IN_OFS, 32'h1234, 1'b1, 32'h2, "t5_collide");
        cpu_rd(STATUS_OFS, 32'h6, "t5_status_err");
        cpu_rd(IN_OFS, 32'h1, "t5_in0_kept");
        cpu_wr(STATUS_OFS, 32'h4, "t5_w1c");
        cpu_rd(STATUS_OFS, 32'h2, "t5_status_clr");
        start(c);
        idle(1);
        access(1'b1, 1'b1, STATUS_OFS, 32'h4, 1'b1, 32'h2, "t5_collide_w1c");
        cpu_rd(STATUS_OFS, 32'h5, "t5_err_stays");
        wait_irq(at);
        check("t5_irq_cycle", DW'(at), DW'(c + 12));
        cpu_wr(STATUS_OFS, 32'h4, "t5_w1c2");

        // 6: re-run with done set, then START+CLR_DONE, then CLR_DONE alone
        start(c);
        check("t6_done_drop", DW'(irq), 0);
        wait_irq(at);
        check("t6_irq_cycle", DW'(at), DW'(c + L + 2));
        c = cyc;
        cpu_wr(CTRL_OFS, 32'h3, "t6_start_clr");
        check("t6_done_drop2", DW'(irq), 0);
        wait_irq(at);
        check("t6_irq_cycle2", DW'(at), DW'(c + L + 2));
        cpu_wr(CTRL_OFS, 32'h2, "t6_clr_done");
        cpu_rd(STATUS_OFS, 32'h0, "t6_status_idle");
        cpu_rd(OUT_OFS + 60, 32'h20, "t6_out15");

        idle(3);
        check("sb_drained", DW'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
